// File: rtl/mgmt_core_wrap.sv
// mgmt_core_wrap: 32-bit counter/timer and 128-bit LA bank on a Wishbone slave.
// Define LA_TIMER_MIRROR_EN to drive la_output[31:0] from the live timer VALUE.
module mgmt_core_wrap #(
   parameter logic [31:0]  BASE_ADR = 32'h2100_0000,
   parameter logic [127:0] LA_RESET = 128'h0
) (
   input  logic         core_clk,
   input  logic         core_rst,
   input  logic         wb_cyc_i,
   input  logic         wb_stb_i,
   input  logic         wb_we_i,
   input  logic [3:0]   wb_sel_i,
   input  logic [31:0]  wb_adr_i,
   input  logic [31:0]  wb_dat_i,
   output logic [31:0]  wb_dat_o,
   output logic         wb_ack_o,
   output logic [127:0] la_output,
   output logic         timer_irq
);
   localparam logic [5:0] A_CONFIG = 6'h00;
   localparam logic [5:0] A_VALUE  = 6'h01;
   localparam logic [5:0] A_DATA   = 6'h02;
   localparam logic [5:0] A_STATUS = 6'h03;
   localparam logic [5:0] A_LA0    = 6'h04;
   localparam logic [5:0] A_LA1    = 6'h05;
   localparam logic [5:0] A_LA2    = 6'h06;
   localparam logic [5:0] A_LA3    = 6'h07;

   logic [3:0]        cfg_q, cfg_d;
   logic [31:0]       value_q, value_d;
   logic [31:0]       data_q, data_d;
   logic              status_q, status_d;
   logic              halt_q, halt_d;
   logic              irq_q, irq_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [3:0][31:0]  la_q, la_d;

   logic        hit, req, wr, rd;
   logic [5:0]  word;
   logic        en, one, up, at_end, run, term, wr_value;
   logic [31:0] rdata;
   logic        unused_adr;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   assign hit        = (wb_adr_i[31:8] == BASE_ADR[31:8]);
   assign req        = wb_cyc_i & wb_stb_i & hit & ~ack_q;
   assign wr         = req & wb_we_i;
   assign rd         = req & ~wb_we_i;
   assign word       = wb_adr_i[7:2];
   assign unused_adr = ^wb_adr_i[1:0];

   assign en       = cfg_q[0];
   assign one      = cfg_q[1];
   assign up       = cfg_q[2];
   assign wr_value = wr & (word == A_VALUE);
   assign at_end   = up ? (value_q == data_q) : (value_q == 32'h0);
   // A finished oneshot stops raising events until it is reprogrammed.
   assign run      = en & ~halt_q;
   assign term     = run & at_end & ~wr_value;

   always_comb begin
      rdata = '0;
      unique case (word)
         A_CONFIG: rdata = {28'h0, cfg_q};
         A_VALUE:  rdata = value_q;
         A_DATA:   rdata = data_q;
         A_STATUS: rdata = {31'h0, status_q};
         A_LA0, A_LA1, A_LA2, A_LA3: rdata = la_q[word[1:0]];
         default:  rdata = '0;
      endcase
   end

   always_comb begin
      cfg_d    = cfg_q;
      value_d  = value_q;
      data_d   = data_q;
      status_d = status_q;
      halt_d   = halt_q;
      la_d     = la_q;
      if (run) begin
         if (at_end) begin
            value_d = one ? value_q : (up ? 32'h0 : data_q);
            halt_d  = one;
         end else begin
            value_d = up ? value_q + 32'd1 : value_q - 32'd1;
         end
      end
      if (wr) begin
         unique case (word)
            A_CONFIG: begin
               if (wb_sel_i[0]) cfg_d = wb_dat_i[3:0];
               halt_d = 1'b0;
            end
            A_VALUE: begin
               value_d = merge(value_q, wb_dat_i, wb_sel_i);
               halt_d  = 1'b0;
            end
            A_DATA: data_d = merge(data_q, wb_dat_i, wb_sel_i);
            A_STATUS: begin
               if (wb_sel_i[0] & wb_dat_i[0]) status_d = 1'b0;
            end
            A_LA0, A_LA1, A_LA2, A_LA3:
               la_d[word[1:0]] = merge(la_q[word[1:0]], wb_dat_i, wb_sel_i);
            default: ;
         endcase
      end
      if (term) status_d = 1'b1;
   end

   assign irq_d = status_d & cfg_d[3];
   assign ack_d = req;
   assign dat_d = rd ? rdata : 32'h0;

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         cfg_q    <= '0;
         value_q  <= '0;
         data_q   <= '0;
         status_q <= 1'b0;
         halt_q   <= 1'b0;
         irq_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         la_q     <= LA_RESET;
      end else begin
         cfg_q    <= cfg_d;
         value_q  <= value_d;
         data_q   <= data_d;
         status_q <= status_d;
         halt_q   <= halt_d;
         irq_q    <= irq_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         la_q     <= la_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign timer_irq = irq_q;

`ifdef LA_TIMER_MIRROR_EN
   assign la_output = {la_q[3], la_q[2], la_q[1], value_q};
`else
   assign la_output = la_q;
`endif
endmodule

// File: tb/tb_mgmt_core_wrap.sv
// Randomized self-checking bench for mgmt_core_wrap against a closed-form timer model.
// Build with LA_TIMER_MIRROR_EN defined to exercise the LA mirror path.
module tb_mgmt_core_wrap;
   localparam logic [31:0] BASE = 32'h2100_0000;

   logic         core_clk = 1'b0;
   logic         core_rst = 1'b1;
   logic         wb_cyc_i = 1'b0;
   logic         wb_stb_i = 1'b0;
   logic         wb_we_i  = 1'b0;
   logic [3:0]   wb_sel_i = 4'h0;
   logic [31:0]  wb_adr_i = 32'h0;
   logic [31:0]  wb_dat_i = 32'h0;
   logic [31:0]  wb_dat_o;
   logic         wb_ack_o;
   logic [127:0] la_output;
   logic         timer_irq;

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;

   logic [31:0] la_m [4];
   logic [31:0] data_m;

   mgmt_core_wrap dut (
      .core_clk  (core_clk),
      .core_rst  (core_rst),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .la_output (la_output),
      .timer_irq (timer_irq)
   );

   always #5 core_clk = ~core_clk;
   always @(posedge core_clk) cyc_n <= cyc_n + 1;

   // Value after k enabled clock edges, from the timer's counting rules.
   function automatic logic [31:0] exp_val(
      input longint unsigned start, input longint unsigned data,
      input bit up, input bit one, input longint unsigned k);
      longint unsigned p;
      p = data + 1;
      if (!up) begin
         if (k <= start) return 32'(start - k);
         if (one) return 32'h0;
         return 32'(data - ((k - start - 1) % p));
      end
      if (one) return (start + k > data) ? 32'(data) : 32'(start + k);
      return 32'((start + k) % p);
   endfunction

   function automatic bit exp_hit(
      input longint unsigned start, input longint unsigned data,
      input bit up, input longint unsigned k);
      return up ? (start + k > data) : (k > start);
   endfunction

   function automatic logic [31:0] bmerge(
      input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   task automatic bus(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rdat, output int ac);
      bit got;
      got = 0;
      rdat = 32'h0;
      ac = -1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge core_clk); #1;
         if (wb_ack_o) begin
            got = 1; rdat = wb_dat_o; ac = cyc_n;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge core_clk); #1;
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL bus_ack adr=%h: got no ack, required ack within 4 cycles", adr);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, output int ac);
      logic [31:0] dummy;
      bus(1'b1, {BASE[31:8], off}, d, s, dummy, ac);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] d, output int ac);
      bus(1'b0, {BASE[31:8], off}, 32'h0, 4'hF, d, ac);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic timer_start(input logic [31:0] start, input logic [31:0] data,
                              input logic [3:0] cfg, output int a);
      int ac;
      wr(8'h00, 32'h0, 4'hF, ac);
      wr(8'h0C, 32'h1, 4'hF, ac);
      wr(8'h04, start, 4'hF, ac);
      wr(8'h08, data, 4'hF, ac);
      data_m = data;
      wr(8'h00, {28'h0, cfg}, 4'hF, a);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      int ac;
      core_rst = 1'b1;
      repeat (40) @(posedge core_clk);
      #1;
      tests++;
      if (la_output !== 128'h0 || wb_ack_o !== 1'b0 || timer_irq !== 1'b0 || wb_dat_o !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs: la=%h ack=%b irq=%b dat=%h, required all 0",
                  la_output, wb_ack_o, timer_irq, wb_dat_o);
      end
      core_rst = 1'b0;
      tick(1);
      for (int i = 0; i < 4; i++) la_m[i] = 32'h0;
      data_m = 32'h0;
      for (int i = 0; i < 4; i++) begin
         rd(8'(4 * i), d, ac);
         tests++;
         if (d !== 32'h0) begin
            fails++;
            $display("FAIL reset_read off=%0h: got %h, required 0", 4 * i, d);
         end
      end
   endtask

   task automatic test_la;
      logic [31:0] d;
      int ac, w;
      logic [31:0] v;
      logic [3:0] s;
      wr(8'h14, 32'h0000_000A, 4'hF, ac);
      la_m[1] = 32'h0000_000A;
      tests++;
      if (la_output[37:32] !== 6'h0a) begin
         fails++;
         $display("FAIL la_code: got %h, required 0a", la_output[37:32]);
      end
      rd(8'h14, d, ac);
      tests++;
      if (d !== 32'h0000_000A) begin
         fails++;
         $display("FAIL la1_readback: got %h, required 0000000a", d);
      end
      wr(8'h18, 32'h1234_5678, 4'hF, ac);
      wr(8'h18, 32'hFFFF_FFFF, 4'b0001, ac);
      la_m[2] = 32'h1234_56FF;
      rd(8'h18, d, ac);
      tests++;
      if (d !== 32'h1234_56FF || la_output[95:64] !== 32'h1234_56FF) begin
         fails++;
         $display("FAIL la_byte_sel: read %h pins %h, required 123456ff", d, la_output[95:64]);
      end
      for (int i = 0; i < 10; i++) begin
         w = $urandom_range(0, 3);
         v = $urandom;
         s = 4'($urandom_range(1, 15));
         wr(8'(8'h10 + 4 * w), v, s, ac);
         la_m[w] = bmerge(la_m[w], v, s);
         rd(8'(8'h10 + 4 * w), d, ac);
         tests++;
         if (d !== la_m[w] || la_output[127:32] !== {la_m[3], la_m[2], la_m[1]}) begin
            fails++;
            $display("FAIL la_rand w=%0d: read %h pins %h, required %h pins %h",
                     w, d, la_output[127:32], la_m[w], {la_m[3], la_m[2], la_m[1]});
         end
`ifndef LA_TIMER_MIRROR_EN
         tests++;
         if (la_output[31:0] !== la_m[0]) begin
            fails++;
            $display("FAIL la_word0_pins: got %h, required %h", la_output[31:0], la_m[0]);
         end
`endif
      end
   endtask

   task automatic check_run(input logic [31:0] start, input logic [31:0] data,
                            input bit up, input bit one, input int a, input int nrd);
      logic [31:0] d, e;
      int r;
      longint unsigned k;
      for (int i = 0; i < nrd; i++) begin
         tick($urandom_range(0, 40));
         rd(8'h04, d, r);
         k = longint'(r - a - 1);
         e = exp_val(start, data, up, one, k);
         tests++;
         if (d !== e) begin
            fails++;
            $display("FAIL timer_value s=%h d=%h up=%b one=%b k=%0d: got %h, required %h",
                     start, data, up, one, k, d, e);
         end
         rd(8'h0C, d, r);
         k = longint'(r - a - 1);
         tests++;
         if (d[0] !== exp_hit(start, data, up, k)) begin
            fails++;
            $display("FAIL timer_status k=%0d: got %b, required %b",
                     k, d[0], exp_hit(start, data, up, k));
         end
      end
   endtask

   task automatic test_down;
      logic [31:0] d, st, dt;
      int a, r;
      timer_start(32'hDCBA_9876, 32'h100, 4'h1, a);
      tick(100);
      rd(8'h04, d, r);
      tests++;
      if (d !== exp_val(32'hDCBA_9876, 32'h100, 0, 0, r - a - 1) || !(d < 32'hDCBA_9876)) begin
         fails++;
         $display("FAIL down_big: got %h, required %h", d,
                  exp_val(32'hDCBA_9876, 32'h100, 0, 0, r - a - 1));
      end
      for (int i = 0; i < 4; i++) begin
         st = $urandom_range(0, 60);
         dt = $urandom_range(0, 20);
         timer_start(st, dt, 4'h1, a);
         check_run(st, dt, 0, 0, a, 3);
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] d;
      int a, r;
      timer_start(32'h19, 32'h19, 4'hB, a);
      tick(10);
      rd(8'h04, d, r);
      tests++;
      if (d !== exp_val(32'h19, 32'h19, 0, 1, r - a - 1)) begin
         fails++;
         $display("FAIL oneshot_mid: got %h, required %h", d,
                  exp_val(32'h19, 32'h19, 0, 1, r - a - 1));
      end
      tick(30);
      for (int i = 0; i < 2; i++) begin
         rd(8'h04, d, r);
         tests++;
         if (d !== 32'h0) begin
            fails++;
            $display("FAIL oneshot_hold: got %h, required 0", d);
         end
      end
      rd(8'h0C, d, r);
      tests++;
      if (d !== 32'h1 || timer_irq !== 1'b1) begin
         fails++;
         $display("FAIL oneshot_flag: status %h irq %b, required 1 and 1", d, timer_irq);
      end
      wr(8'h0C, 32'h1, 4'hF, r);
      tests++;
      if (timer_irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_clear: got %b, required 0", timer_irq);
      end
      rd(8'h0C, d, r);
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL status_clear: got %h, required 0", d);
      end
   endtask

   task automatic test_up;
      logic [31:0] st, dt;
      logic [3:0] c;
      int a;
      timer_start(32'h0, 32'h0F, 4'h5, a);
      check_run(32'h0, 32'h0F, 1, 0, a, 6);
      for (int i = 0; i < 4; i++) begin
         dt = $urandom_range(1, 40);
         st = $urandom_range(0, dt);
         c = 4'h5 | (4'($urandom_range(0, 1)) << 1);
         timer_start(st, dt, c, a);
         check_run(st, dt, 1, c[1], a, 3);
      end
      timer_start(32'hFFFF_FFF8, 32'hFFFF_FFFF, 4'h5, a);
      check_run(32'hFFFF_FFF8, 32'hFFFF_FFFF, 1, 0, a, 2);
   endtask

   task automatic test_value_override;
      logic [31:0] d;
      int a, w, r;
      timer_start(32'd500, 32'd1000, 4'h1, a);
      tick(10);
      wr(8'h04, 32'h77, 4'hF, w);
      tick(5);
      rd(8'h04, d, r);
      tests++;
      if (d !== exp_val(32'h77, 32'd1000, 0, 0, r - w - 1)) begin
         fails++;
         $display("FAIL value_override: got %h, required %h", d,
                  exp_val(32'h77, 32'd1000, 0, 0, r - w - 1));
      end
   endtask

   task automatic test_mirror;
      int a, bad;
      logic [31:0] e;
      bad = 0;
      timer_start(32'h12BC, 32'h12BC, 4'h1, a);
      for (int i = 0; i < 30; i++) begin
         @(posedge core_clk); #1;
`ifdef LA_TIMER_MIRROR_EN
         e = exp_val(32'h12BC, 32'h12BC, 0, 0, cyc_n - a);
`else
         e = la_m[0];
`endif
         if (la_output[31:0] !== e) begin
            bad++;
            if (bad == 1)
               $display("FAIL la_word0_track cyc=%0d: got %h, required %h", i, la_output[31:0], e);
         end
      end
      tests++;
      if (bad != 0) fails++;
   endtask

   task automatic test_window;
      logic [31:0] d;
      int ac, acks;
      acks = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 32'h2200_0014; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(posedge core_clk); #1;
         if (wb_ack_o) acks++;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      tick(1);
      tests++;
      if (acks != 0) begin
         fails++;
         $display("FAIL miss_ack: got %0d acks, required 0", acks);
      end
      rd(8'h14, d, ac);
      tests++;
      if (d !== la_m[1]) begin
         fails++;
         $display("FAIL miss_nowrite: got %h, required %h", d, la_m[1]);
      end
      wr(8'h40, 32'hFFFF_FFFF, 4'hF, ac);
      rd(8'h40, d, ac);
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL unmapped_read: got %h, required 0", d);
      end
   endtask

   task automatic test_back_to_back;
      logic ea;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = BASE | 32'h08; wb_sel_i = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(posedge core_clk); #1;
         ea = (i % 2 == 0);
         tests++;
         if (wb_ack_o !== ea || (ea && wb_dat_o !== data_m)) begin
            fails++;
            $display("FAIL b2b_ack i=%0d: ack %b dat %h, required ack %b dat %h",
                     i, wb_ack_o, wb_dat_o, ea, data_m);
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick(1);
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      int a, r;
      timer_start(32'h3, 32'h3, 4'h9, a);
      tick(10);
      tests++;
      if (timer_irq !== 1'b1) begin
         fails++;
         $display("FAIL mid_irq_pre: got %b, required 1", timer_irq);
      end
      core_rst = 1'b1;
      #1;
      tests++;
      if (timer_irq !== 1'b0 || la_output !== 128'h0 || wb_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: irq %b la %h ack %b, required 0", timer_irq, la_output, wb_ack_o);
      end
      for (int i = 0; i < 4; i++) la_m[i] = 32'h0;
      data_m = 32'h0;
      tick(3);
      core_rst = 1'b0;
      tick(10);
      for (int i = 0; i < 4; i++) begin
         rd(8'(4 * i), d, r);
         tests++;
         if (d !== 32'h0 || timer_irq !== 1'b0) begin
            fails++;
            $display("FAIL mid_after off=%0h: got %h irq %b, required 0", 4 * i, d, timer_irq);
         end
      end
   endtask

   initial begin
      test_reset;
      test_la;
      test_down;
      test_oneshot;
      test_up;
      test_value_override;
      test_mirror;
      test_window;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end
endmodule
